// File: rtl/sdm_pkg.sv
// Shared types and helpers for the FLB fractional-N SDM sequencer and its
// window-average monitor.
package sdm_pkg;

    localparam int unsigned OS_W  = 8;
    localparam int unsigned MAN_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RAMP   = 3'd2,
        ST_RUN    = 3'd3,
        ST_RAMPDN = 3'd4
    } sdm_state_e;

    // Ideal window sum: each os_bin sample averages 1 + frac/256.
    function automatic int unsigned exp_sum(input int unsigned win_log2,
                                            input logic [OS_W-1:0] tgt);
        return (32'd1 << win_log2) + (32'(tgt) << (win_log2 - 32'd8));
    endfunction

    // One saturating ramp step toward tgt; never passes it.
    function automatic logic [OS_W-1:0] ramp_next(input logic [OS_W-1:0] cur,
                                                  input logic [OS_W-1:0] tgt,
                                                  input logic [OS_W-1:0] step);
        logic [OS_W-1:0] diff;
        if (cur < tgt) begin
            diff = tgt - cur;
            return (diff > step) ? cur + step : tgt;
        end
        diff = cur - tgt;
        return (diff > step) ? cur - step : tgt;
    endfunction

endpackage

// File: rtl/sdm_avg_mon.sv
// Window accumulator: sums a 2-bit stream over 2^WIN_LOG2 enabled cycles and
// flags a sticky error when the sum strays from the ideal by more than MON_TOL.
module sdm_avg_mon
    import sdm_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = 10,
    parameter int unsigned MON_TOL  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  err_clr_i,
    input  logic [OS_W-1:0]       tgt_i,
    input  logic [1:0]            sample_i,
    output logic                  valid_o,
    output logic [WIN_LOG2+1:0]   sum_o,
    output logic                  err_o
);

    localparam int unsigned SUM_W = WIN_LOG2 + 2;

    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0]    acc_q, acc_d, acc_nxt;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    int unsigned         exp_w;
    int unsigned         dev;

    always_comb begin
        acc_nxt = acc_q + SUM_W'(sample_i);
        exp_w   = exp_sum(WIN_LOG2, tgt_i);
        dev     = (32'(acc_nxt) > exp_w) ? 32'(acc_nxt) - exp_w : exp_w - 32'(acc_nxt);
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        valid_d = 1'b0;
        err_d   = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        // Dropping enable throws away any partial window.
        if (!en_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (&cnt_q) begin
            sum_d   = acc_nxt;
            valid_d = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            if (dev > MON_TOL) begin
                err_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            acc_d = acc_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign err_o   = err_q;

endmodule

// File: rtl/sdm_seq_ctrl.sv
// Start-up / retarget / ramp-down sequencer for the FLB fractional-N SDM,
// with a window-average monitor of the SDM's binary output.
module sdm_seq_ctrl
    import sdm_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned RAMP_STEP  = 4,
    parameter int unsigned RAMP_DIV   = 2,
    parameter int unsigned WIN_LOG2   = 10,
    parameter int unsigned MON_TOL    = 4
) (
    input  logic                  nsh_clk,
    input  logic                  nsh_rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  retarget,
    input  logic [OS_W-1:0]       frac_tgt,
    input  logic                  order_req,
    input  logic                  man_on_req,
    input  logic [MAN_W-1:0]      man_val_req,
    input  logic                  thrm_en_req,
    input  logic [1:0]            os_bin,
    output logic                  sdm_on,
    output logic                  sdm_order,
    output logic                  sdm_man_on,
    output logic                  sdm_thrm_en,
    output logic [OS_W-1:0]       os_data,
    output logic [MAN_W-1:0]      sdm_man_val,
    output logic                  busy,
    output logic                  locked,
    output logic                  mon_valid,
    output logic [WIN_LOG2+1:0]   mon_sum,
    output logic                  mon_err
);

    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [OS_W-1:0] STEP = OS_W'(RAMP_STEP);

    sdm_state_e       state_q, state_d;
    logic [OS_W-1:0]  tgt_q, tgt_d, tgt_eff;
    logic [OS_W-1:0]  os_q, os_d;
    logic             on_q, on_d;
    logic             order_q, order_d;
    logic             man_on_q, man_on_d;
    logic [MAN_W-1:0] man_val_q, man_val_d;
    logic             thrm_q, thrm_d;
    logic             busy_q, busy_d;
    logic             locked_q, locked_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             div_hit;
    logic             mon_en, mon_clr;

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        tgt_eff   = tgt_q;
        os_d      = os_q;
        on_d      = on_q;
        order_d   = order_q;
        man_on_d  = man_on_q;
        man_val_d = man_val_q;
        thrm_d    = thrm_q;
        settle_d  = settle_q;
        div_d     = div_q;
        div_hit   = (div_q == DIV_W'(RAMP_DIV - 1));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SETTLE;
                    tgt_d     = frac_tgt;
                    order_d   = order_req;
                    man_on_d  = man_on_req;
                    man_val_d = man_val_req;
                    thrm_d    = thrm_en_req;
                    settle_d  = '0;
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    state_d = ST_RAMPDN;
                    div_d   = '0;
                end else if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                    state_d = ST_RAMP;
                    on_d    = 1'b1;
                    div_d   = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_RAMP: begin
                if (stop) begin
                    state_d = ST_RAMPDN;
                    div_d   = '0;
                end else begin
                    // A retarget mid-ramp takes effect on this very cycle's decision.
                    if (retarget) begin
                        tgt_eff = frac_tgt;
                        tgt_d   = frac_tgt;
                    end
                    if (os_q == tgt_eff) begin
                        state_d = ST_RUN;
                    end else if (div_hit) begin
                        div_d = '0;
                        os_d  = ramp_next(os_q, tgt_eff, STEP);
                        if (os_d == tgt_eff) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_RAMPDN;
                    div_d   = '0;
                end else if (retarget) begin
                    state_d = ST_RAMP;
                    tgt_d   = frac_tgt;
                    div_d   = '0;
                end
            end
            ST_RAMPDN: begin
                if (os_q == '0) begin
                    state_d   = ST_IDLE;
                    on_d      = 1'b0;
                    tgt_d     = '0;
                    order_d   = 1'b0;
                    man_on_d  = 1'b0;
                    man_val_d = '0;
                    thrm_d    = 1'b0;
                end else if (div_hit) begin
                    div_d = '0;
                    os_d  = ramp_next(os_q, '0, STEP);
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // RUN is only ever entered with os_data on target, so state alone gives lock.
        busy_d   = (state_d != ST_IDLE);
        locked_d = (state_d == ST_RUN);
    end

    always_ff @(posedge nsh_clk or negedge nsh_rst_n) begin
        if (!nsh_rst_n) begin
            state_q   <= ST_IDLE;
            tgt_q     <= '0;
            os_q      <= '0;
            on_q      <= 1'b0;
            order_q   <= 1'b0;
            man_on_q  <= 1'b0;
            man_val_q <= '0;
            thrm_q    <= 1'b0;
            busy_q    <= 1'b0;
            locked_q  <= 1'b0;
            settle_q  <= '0;
            div_q     <= '0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            os_q      <= os_d;
            on_q      <= on_d;
            order_q   <= order_d;
            man_on_q  <= man_on_d;
            man_val_q <= man_val_d;
            thrm_q    <= thrm_d;
            busy_q    <= busy_d;
            locked_q  <= locked_d;
            settle_q  <= settle_d;
            div_q     <= div_d;
        end
    end

    assign mon_en  = (state_q == ST_RUN) && !man_on_q;
    assign mon_clr = (state_q == ST_IDLE) && start;

    sdm_avg_mon #(
        .WIN_LOG2 (WIN_LOG2),
        .MON_TOL  (MON_TOL)
    ) u_mon (
        .clk_i     (nsh_clk),
        .rst_ni    (nsh_rst_n),
        .en_i      (mon_en),
        .err_clr_i (mon_clr),
        .tgt_i     (tgt_q),
        .sample_i  (os_bin),
        .valid_o   (mon_valid),
        .sum_o     (mon_sum),
        .err_o     (mon_err)
    );

    assign sdm_on      = on_q;
    assign sdm_order   = order_q;
    assign sdm_man_on  = man_on_q;
    assign sdm_man_val = man_val_q;
    assign sdm_thrm_en = thrm_q;
    assign os_data     = os_q;
    assign busy        = busy_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_sdm_seq_ctrl.sv
// Scoreboard bench for sdm_seq_ctrl: stimulus queues expected events, a
// negedge monitor pops and checks them as the DUT produces them.
module tb_sdm_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, retarget = 1'b0;
    logic [7:0]  frac = 8'h00;
    logic        order = 1'b0, man_on = 1'b0, thrm = 1'b0;
    logic [2:0]  man_val = 3'd0;
    logic [1:0]  os_bin = 2'd0;

    logic        sdm_on, sdm_order, sdm_man_on, sdm_thrm_en;
    logic [7:0]  os_data;
    logic [2:0]  sdm_man_val;
    logic        busy, locked, mon_valid, mon_err;
    logic [11:0] mon_sum;

    sdm_seq_ctrl #(
        .SETTLE_CYC (8),
        .RAMP_STEP  (4),
        .RAMP_DIV   (2),
        .WIN_LOG2   (10),
        .MON_TOL    (4)
    ) dut (
        .nsh_clk     (clk),
        .nsh_rst_n   (rst_n),
        .start       (start),
        .stop        (stop),
        .retarget    (retarget),
        .frac_tgt    (frac),
        .order_req   (order),
        .man_on_req  (man_on),
        .man_val_req (man_val),
        .thrm_en_req (thrm),
        .os_bin      (os_bin),
        .sdm_on      (sdm_on),
        .sdm_order   (sdm_order),
        .sdm_man_on  (sdm_man_on),
        .sdm_thrm_en (sdm_thrm_en),
        .os_data     (os_data),
        .sdm_man_val (sdm_man_val),
        .busy        (busy),
        .locked      (locked),
        .mon_valid   (mon_valid),
        .mon_sum     (mon_sum),
        .mon_err     (mon_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input int unsigned act);
        checks++;
        errors++;
        $display("FAIL %s: got event value %0d, expected no event (cycle %0d)", name, act, cyc);
    endtask

    // Ideal first-order SDM stand-in: mean output is 1 + frac/256.
    int unsigned sdm_mode = 0;
    logic [7:0]  sdm_frac = 8'h00;
    logic [7:0]  sdm_acc  = 8'h00;
    logic [8:0]  sdm_tmp;
    always @(negedge clk) begin
        if (sdm_mode == 1) begin
            sdm_tmp = {1'b0, sdm_acc} + {1'b0, sdm_frac};
            sdm_acc = sdm_tmp[7:0];
            os_bin  = sdm_tmp[8] ? 2'd2 : 2'd1;
        end else if (sdm_mode == 2) begin
            os_bin = 2'd2;
        end else begin
            os_bin = 2'd0;
        end
    end

    typedef struct { int unsigned val; int unsigned cyc; } ev_t;
    typedef struct { int unsigned sum; int unsigned err; } mon_t;
    ev_t         q_os[$];
    int unsigned q_on[$];
    int unsigned q_lock[$];
    mon_t        q_mon[$];

    logic [7:0]  prev_os = 8'h00;
    logic        prev_on = 1'b0, prev_lock = 1'b0;
    int unsigned n_valid = 0;
    ev_t         m_ev;
    mon_t        m_mon;
    int unsigned m_c;

    always @(negedge clk) begin
        if (os_data != prev_os) begin
            if (q_os.size() == 0) unexpected("os_data change", os_data);
            else begin
                m_ev = q_os.pop_front();
                chk("os_data step value", os_data, m_ev.val);
                chk("os_data step cycle", cyc, m_ev.cyc);
            end
        end
        if (sdm_on && !prev_on) begin
            if (q_on.size() == 0) unexpected("sdm_on rise", cyc);
            else begin
                m_c = q_on.pop_front();
                chk("sdm_on rise cycle", cyc, m_c);
            end
        end
        if (locked && !prev_lock) begin
            if (q_lock.size() == 0) unexpected("locked rise", cyc);
            else begin
                m_c = q_lock.pop_front();
                chk("locked rise cycle", cyc, m_c);
            end
        end
        if (mon_valid) begin
            n_valid++;
            if (q_mon.size() == 0) unexpected("mon_valid", mon_sum);
            else begin
                m_mon = q_mon.pop_front();
                chk("mon_sum", mon_sum, m_mon.sum);
                chk("mon_err at window", mon_err, m_mon.err);
            end
        end
        prev_os   = os_data;
        prev_on   = sdm_on;
        prev_lock = locked;
    end

    task automatic pulse_start(output int unsigned n);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = cyc;
    endtask

    // Ramp rule: step of min(4, |diff|) every 2 cycles after entry edge t0.
    task automatic push_ramp(input int unsigned from, input int unsigned to,
                             input int unsigned t0, output int unsigned t_end);
        int unsigned v = from;
        int unsigned k = 0;
        ev_t e;
        while (v != to) begin
            k++;
            if (to > v) v = (to - v > 4) ? v + 4 : to;
            else        v = (v - to > 4) ? v - 4 : to;
            e.val = v;
            e.cyc = t0 + 2 * k;
            q_os.push_back(e);
        end
        t_end = t0 + 2 * k;
    endtask

    task automatic wait_valid(input int unsigned bound);
        int unsigned k = 0;
        @(posedge clk); #1;
        while (!mon_valid && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        if (!mon_valid) begin
            checks++; errors++;
            $display("FAIL mon_valid wait: got no pulse in %0d cycles, expected a pulse", bound);
        end
    endtask

    task automatic wait_level(input string name, input bit want_busy, input int unsigned bound,
                              output int unsigned t);
        int unsigned k = 0;
        while (((want_busy ? busy : locked) == 1'b0) == want_busy ? 1'b0 : 1'b0) k = k;
        while ((want_busy ? (busy != 1'b0) : (locked != 1'b1)) && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (k >= bound) begin
            checks++; errors++;
            $display("FAIL %s wait: got timeout after %0d cycles, expected state change", name, bound);
        end
        t = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    int unsigned n, t, r, s, vbase;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset sdm_on", sdm_on, 0);
        chk("reset os_data", os_data, 0);
        chk("reset locked", locked, 0);
        chk("reset mon_valid", mon_valid, 0);
        chk("reset mon_sum", mon_sum, 0);
        chk("reset mon_err", mon_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Start-up ramp 0 -> 0x40, order 1
        sdm_mode = 1; sdm_frac = 8'h40;
        frac = 8'h40; order = 1'b1; thrm = 1'b1; man_on = 1'b0; man_val = 3'd0;
        pulse_start(n);
        frac = 8'hC3; order = 1'b0; thrm = 1'b0;
        q_on.push_back(n + 8);
        push_ramp(0, 64, n + 8, t);
        q_lock.push_back(t);
        q_mon.push_back('{1280, 0});
        chk("busy after start", busy, 1);
        chk("sdm_thrm_en latched", sdm_thrm_en, 1);
        repeat (7) @(negedge clk);
        chk("sdm_on held low in settle", sdm_on, 0);
        chk("sdm_order latched", sdm_order, 1);
        wait_level("lock", 1'b0, 60, t);
        chk("os_data at lock", os_data, 64);

        // Monitor windows: ideal, forced 2, ideal again (error sticky)
        wait_valid(1200);
        sdm_mode = 2;
        q_mon.push_back('{2048, 1});
        wait_valid(1100);
        sdm_mode = 1;
        q_mon.push_back('{1280, 1});
        wait_valid(1100);

        // Retarget 0x42 in RUN
        @(negedge clk); retarget = 1'b1; frac = 8'h42; sdm_frac = 8'h42;
        @(negedge clk); retarget = 1'b0; frac = 8'h00;
        r = cyc;
        chk("locked drops on retarget", locked, 0);
        q_os.push_back('{66, r + 2});
        q_lock.push_back(r + 2);
        q_mon.push_back('{1288, 1});
        wait_valid(1200);

        // Stop and retarget together: stop wins
        @(negedge clk); stop = 1'b1; retarget = 1'b1; frac = 8'h80;
        @(negedge clk); stop = 1'b0; retarget = 1'b0;
        s = cyc;
        chk("locked drops on stop", locked, 0);
        chk("sdm_on during ramp-down", sdm_on, 1);
        push_ramp(66, 0, s, t);
        wait_level("idle after stop", 1'b1, 100, r);
        chk("idle cycle after ramp-down", r, t + 1);
        chk("sdm_on after stop", sdm_on, 0);
        chk("os_data after stop", os_data, 0);
        chk("sdm_order cleared in idle", sdm_order, 0);

        // Async reset mid-RAMP
        frac = 8'h80; order = 1'b0; thrm = 1'b0;
        pulse_start(n);
        chk("mon_err cleared by start", mon_err, 0);
        q_on.push_back(n + 8);
        q_os.push_back('{4, n + 10});
        q_os.push_back('{8, n + 12});
        q_os.push_back('{12, n + 14});
        while (cyc < n + 14) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        q_os.push_back('{0, n + 15});
        #1;
        chk("async reset sdm_on", sdm_on, 0);
        chk("async reset os_data", os_data, 0);
        chk("async reset busy", busy, 0);
        chk("async reset thrm", sdm_thrm_en, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Manual mode restart: monitor must stay silent
        frac = 8'h10; order = 1'b0; thrm = 1'b1; man_on = 1'b1; man_val = 3'd5;
        sdm_frac = 8'h10;
        pulse_start(n);
        man_on = 1'b0; man_val = 3'd0;
        chk("sdm_man_on", sdm_man_on, 1);
        chk("sdm_man_val", sdm_man_val, 5);
        chk("sdm_thrm_en restart", sdm_thrm_en, 1);
        q_on.push_back(n + 8);
        push_ramp(0, 16, n + 8, t);
        q_lock.push_back(t);
        vbase = n_valid;
        repeat (1100) @(negedge clk);
        chk("mon_valid pulses in manual mode", n_valid - vbase, 0);
        chk("locked in manual run", locked, 1);
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        s = cyc;
        push_ramp(16, 0, s, t);
        wait_level("idle after manual stop", 1'b1, 100, r);
        chk("manual idle cycle", r, t + 1);
        chk("sdm_man_on cleared", sdm_man_on, 0);

        repeat (3) @(negedge clk);
        chk("leftover os_data events", q_os.size(), 0);
        chk("leftover sdm_on events", q_on.size(), 0);
        chk("leftover locked events", q_lock.size(), 0);
        chk("leftover monitor windows", q_mon.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
